mem_sink_responder: RTL and testbench

- Memory-side responder for the path arbiter's outbound req/gnt/valid interface.
- Answers req_i with gnt_o under space-based flow control and tracks outstanding grants as credits.
- Captures each granted byte into an internal FIFO; a local drain port reads the FIFO out.
- Sits where the bench memory model sat; used as synthesizable sink and as a reusable checker of arbiter-side protocol errors.

---
 rtl/mem_sink_responder.sv | 116 +++++++++++
 tb/tb_mem_sink_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sink_responder.sv
// Memory-side responder: grants slots under space/credit flow control, buffers granted bytes in a FIFO, drains locally.
// Optional grant throttle enabled by defining GNT_THROTTLE_EN (default build: throttle always permissive).
module mem_sink_responder #(
    parameter int          DEPTH       = 16,
    parameter int          MAX_CREDIT  = 4,
    parameter logic [15:0] GNT_PATTERN = 16'hE1C7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_i,
    output logic                          gnt_o,
    input  logic                          valid_i,
    input  logic [7:0]                    data_i,
    input  logic                          rd_en_i,
    output logic [7:0]                    rd_data_o,
    output logic                          rd_valid_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic [$clog2(MAX_CREDIT):0]   credit_o,
    output logic                          err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(MAX_CREDIT) + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_r;
    logic [KW-1:0] credit_r;
    logic          gnt_r;
    logic          err_r;
    logic          rd_valid_r;
    logic [7:0]    rd_data_r;

    logic credit_avail;
    logic beat_take;
    logic fifo_full;
    logic wr_en;
    logic rd_take;
    logic throttle_ok;
    logic gnt_next;
    logic err_next;

`ifdef GNT_THROTTLE_EN
    logic [3:0] phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 4'd0;
        end else if (req_i) begin
            phase <= phase + 4'd1;
        end
    end

    assign throttle_ok = GNT_PATTERN[phase];
`else
    logic unused_gnt_pattern;
    assign unused_gnt_pattern = ^GNT_PATTERN;
    assign throttle_ok        = 1'b1;
`endif

    // A grant issued this cycle already counts as a credit, so a beat may ride on it.
    always_comb begin
        credit_avail = (credit_r != '0) || gnt_r;
        beat_take    = valid_i && credit_avail;
        fifo_full    = (count_r == CW'(DEPTH));
        wr_en        = beat_take && !fifo_full;
        rd_take      = rd_en_i && (count_r != '0);
        err_next     = err_r || (valid_i && !credit_avail) || (beat_take && fifo_full);
        gnt_next     = req_i
                    && ((int'(count_r) + int'(credit_r) + int'(gnt_r)) < DEPTH)
                    && ((int'(credit_r) + int'(gnt_r)) < MAX_CREDIT)
                    && throttle_ok;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            credit_r   <= '0;
            gnt_r      <= 1'b0;
            err_r      <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 8'd0;
        end else begin
            gnt_r      <= gnt_next;
            err_r      <= err_next;
            credit_r   <= credit_r + KW'(gnt_r) - KW'(beat_take);
            count_r    <= count_r + CW'(wr_en) - CW'(rd_take);
            rd_valid_r <= rd_take;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_take) begin
                rd_data_r <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
        end
    end

    assign gnt_o      = gnt_r;
    assign err_o      = err_r;
    assign credit_o   = credit_r;
    assign count_o    = count_r;
    assign rd_valid_o = rd_valid_r;
    assign rd_data_o  = rd_data_r;

endmodule

// File: tb/tb_mem_sink_responder.sv
// Self-checking bench for mem_sink_responder: vector table, directed corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_mem_sink_responder;

    localparam int          DEPTH       = 16;
    localparam int          MAX_CREDIT  = 4;
    localparam logic [15:0] GNT_PATTERN = 16'hE1C7;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_i;
    logic       gnt_o;
    logic       valid_i;
    logic [7:0] data_i;
    logic       rd_en_i;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic [4:0] count_o;
    logic [2:0] credit_o;
    logic       err_o;

    mem_sink_responder #(
        .DEPTH(DEPTH), .MAX_CREDIT(MAX_CREDIT), .GNT_PATTERN(GNT_PATTERN)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o),
        .valid_i(valid_i), .data_i(data_i), .rd_en_i(rd_en_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .count_o(count_o), .credit_o(credit_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: stored bytes live in a queue, credits are a plain integer.
    bit         m_gnt;
    int         m_credit;
    logic [7:0] m_q [$];
    bit         m_err;
    bit         m_rd_valid;
    logic [7:0] m_rd_data;
    int         m_phase;

    typedef struct {
        bit         rst;
        bit         req;
        bit         valid;
        logic [7:0] data;
        bit         rd_en;
        bit         exp_gnt;
        int         exp_count;
        int         exp_credit;
        bit         exp_err;
        bit         exp_rd_valid;
        logic [7:0] exp_rd_data;
    } vec_t;

    vec_t vecs [$];

    task automatic checkEq(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic applyStimulus(input bit r, input bit rq, input bit v, input logic [7:0] d, input bit re);
        bit         avail;
        bit         full;
        bit         permit;
        bit         n_gnt;
        int         used;
        rst = r; req_i = rq; valid_i = v; data_i = d; rd_en_i = re;
        if (r) begin
            m_gnt = 0; m_credit = 0; m_q.delete(); m_err = 0;
            m_rd_valid = 0; m_rd_data = 8'd0; m_phase = 0;
        end else begin
            avail = (m_credit > 0) || m_gnt;
            full  = (m_q.size() == DEPTH);
            used  = m_q.size() + m_credit + int'(m_gnt);
`ifdef GNT_THROTTLE_EN
            permit = GNT_PATTERN[m_phase];
`else
            permit = 1'b1;
`endif
            n_gnt = rq && (used < DEPTH) && (m_credit + int'(m_gnt) < MAX_CREDIT) && permit;
            if (re && m_q.size() > 0) begin
                m_rd_data  = m_q.pop_front();
                m_rd_valid = 1;
            end else begin
                m_rd_valid = 0;
            end
            if (v && !avail) m_err = 1;
            if (v && avail) begin
                if (full) m_err = 1;
                else m_q.push_back(d);
            end
            m_credit = m_credit + int'(m_gnt) - int'(v && avail);
            m_gnt    = n_gnt;
            if (rq) m_phase = (m_phase + 1) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        checkEq("gnt_o", int'(gnt_o), int'(m_gnt));
        checkEq("count_o", int'(count_o), m_q.size());
        checkEq("credit_o", int'(credit_o), m_credit);
        checkEq("err_o", int'(err_o), int'(m_err));
        checkEq("rd_valid_o", int'(rd_valid_o), int'(m_rd_valid));
        checkEq("rd_data_o", int'(rd_data_o), int'(m_rd_data));
    endtask

    task automatic step(input bit rq, input bit v, input logic [7:0] d, input bit re);
        applyStimulus(1'b0, rq, v, d, re);
        checkOutput();
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput();
    endtask

    initial begin
        int pulses;
        int seen;
        int sent;
        int got;
        int max_count;
        bit g_prev;
        bit g_cur;
        bit v;
        bit r;

        rst = 1'b1; req_i = 1'b0; valid_i = 1'b0; data_i = 8'd0; rd_en_i = 1'b0;

        // rst req val data rd | gnt cnt cred err rdv rdd
        vecs.push_back('{1, 0, 0, 8'h00, 0,  0, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{0, 0, 1, 8'h5A, 0,  0, 0, 0, 1, 0, 8'h00});
        vecs.push_back('{0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 0, 8'h00});
        vecs.push_back('{1, 0, 0, 8'h00, 0,  0, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{0, 1, 0, 8'h00, 0,  1, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{0, 0, 0, 8'h00, 0,  0, 0, 1, 0, 0, 8'h00});
        vecs.push_back('{0, 0, 1, 8'h11, 0,  0, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 1, 8'h11});
        vecs.push_back('{0, 0, 0, 8'h00, 0,  0, 0, 0, 0, 0, 8'h11});
        vecs.push_back('{0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 0, 8'h11});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].valid, vecs[i].data, vecs[i].rd_en);
            checkOutput();
            checkEq($sformatf("vec%0d_gnt", i), int'(gnt_o), int'(vecs[i].exp_gnt));
            checkEq($sformatf("vec%0d_count", i), int'(count_o), vecs[i].exp_count);
            checkEq($sformatf("vec%0d_credit", i), int'(credit_o), vecs[i].exp_credit);
            checkEq($sformatf("vec%0d_err", i), int'(err_o), int'(vecs[i].exp_err));
            checkEq($sformatf("vec%0d_rd_valid", i), int'(rd_valid_o), int'(vecs[i].exp_rd_valid));
            checkEq($sformatf("vec%0d_rd_data", i), int'(rd_data_o), int'(vecs[i].exp_rd_data));
        end

`ifndef GNT_THROTTLE_EN
        // Basic flow: every grant answered one cycle later with bytes 01..10.
        resetDut();
        step(1, 0, 8'h00, 0);
        checkEq("first_gnt_latency", int'(gnt_o), 1);
        g_prev = 0; sent = 0;
        for (int c = 0; c < 30; c++) begin
            g_cur = m_gnt;
            v = g_prev;
            step(1, v, 8'(sent + 1), 0);
            if (v) sent++;
            g_prev = g_cur;
        end
        checkEq("basic_count_full", int'(count_o), 16);
        checkEq("basic_gnt_while_full", int'(gnt_o), 0);
        checkEq("basic_err", int'(err_o), 0);
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 8'h00, 1);
            checkEq($sformatf("basic_drain%0d", k), int'(rd_data_o), k + 1);
        end
`endif

        // Credit cap: no beats, so at most MAX_CREDIT grants may be outstanding.
        resetDut();
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            step(1, 0, 8'h00, 0);
            if (gnt_o) pulses++;
        end
`ifndef GNT_THROTTLE_EN
        checkEq("cap_pulses", pulses, 4);
        checkEq("cap_credit", int'(credit_o), 4);
`endif
        if (m_credit > 0) begin
            step(1, 1, 8'hA5, 0);
`ifndef GNT_THROTTLE_EN
            checkEq("cap_credit_after_beat", int'(credit_o), 3);
`endif
            seen = 0;
            for (int c = 0; c < 3; c++) begin
                step(1, 0, 8'h00, 0);
                if (gnt_o) seen = 1;
            end
`ifndef GNT_THROTTLE_EN
            checkEq("cap_regrant", seen, 1);
`endif
        end

        // Reset mid-burst with beats stored and credits outstanding.
        resetDut();
        for (int c = 0; c < 5; c++) step(1, 0, 8'h00, 0);
        for (int c = 0; c < 3; c++) step(0, m_credit > 0 || m_gnt, 8'(8'h30 + c), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
        checkOutput();
        checkEq("rst_gnt", int'(gnt_o), 0);
        checkEq("rst_count", int'(count_o), 0);
        checkEq("rst_credit", int'(credit_o), 0);
        checkEq("rst_err", int'(err_o), 0);
        step(0, 1, 8'h99, 0);
        checkEq("rst_late_beat_err", int'(err_o), 1);

        // Drain ordering with pointer wrap: 20 beats, one drain every other cycle.
        resetDut();
        g_prev = 0; sent = 0; got = 0; max_count = 0;
        for (int c = 0; c < 300 && got < 20; c++) begin
            g_cur = m_gnt;
            v = g_prev && (sent < 20);
            step(sent < 20, v, 8'(sent), (c % 2) == 0);
            if (v) sent++;
            if (rd_valid_o) begin
                checkEq($sformatf("drain_order%0d", got), int'(rd_data_o), got);
                got++;
            end
            if (int'(count_o) > max_count) max_count = int'(count_o);
            g_prev = g_cur;
        end
        checkEq("drain_all_received", got, 20);
        checkEq("drain_count_bounded", int'(max_count <= 16), 1);
        checkEq("drain_no_err", int'(err_o), 0);

`ifdef GNT_THROTTLE_EN
        begin
            logic [15:0] pat;
            pat = GNT_PATTERN;
            resetDut();
            g_prev = 0;
            for (int c = 0; c < 16; c++) begin
                g_cur = m_gnt;
                step(1, g_prev, 8'(c), 1);
                checkEq($sformatf("throttle_gnt%0d", c), int'(gnt_o), int'(pat[c]));
                g_prev = g_cur;
            end
        end
`endif

        // Randomized traffic with occasional reset and stray beats.
        resetDut();
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 63) == 0);
            v = m_gnt ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            applyStimulus(r, $urandom_range(0, 3) != 0, v, 8'($urandom), $urandom_range(0, 2) == 0);
            checkOutput();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
